// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline IF stage.
package pipe_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  typedef enum logic {FETCH, HOLD} if_state_t;
endpackage

// File: rtl/pipe_npc_mux.sv
// pipe_npc_mux: 4:1 next-PC select from pc+4, branch, jr and jump targets.
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_da,
  input  logic [31:0] i_jpc,
  output logic [31:0] o_npc
);
  always_comb
    o_npc = (i_sel == PCSRC_BR) ? i_bpc :
            (i_sel == PCSRC_JR) ? i_da  :
            (i_sel == PCSRC_J)  ? i_jpc : i_pc4;
endmodule

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: PC, instruction fetch handshake and IF/ID register.
// Define PIPE_IF_SQUASH_EN to squash the branch delay slot instead of issuing it.
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);
  if_state_t   r_state, w_state;
  logic [31:0] r_pc, w_pc, r_dinst, w_dinst, r_dpc4, w_dpc4;
  logic [31:0] r_ibuf, w_ibuf, r_redir_pc, w_redir_pc;
  logic        r_dvalid, w_dvalid, r_redir_pend, w_redir_pend, r_started;
  logic [31:0] w_pc4, w_tgt, w_word;
  logic        w_done, w_take, w_redir, w_squash;

  pipe_npc_mux u_npc_mux (
    .i_sel(pcsource),
    .i_pc4(w_pc4),
    .i_bpc(bpc),
    .i_da (da),
    .i_jpc(jpc),
    .o_npc(w_tgt)
  );

  // r_started keeps the request low for the first cycle after reset release
  assign imem_req  = r_started & (r_state == FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dinst     = r_dinst;
  assign dpc4      = r_dpc4;
  assign dvalid    = r_dvalid;
  assign w_pc4     = r_pc + 32'd4;
  assign w_done    = imem_req & imem_ready;
  assign w_take    = wpcir & ((r_state == HOLD) | w_done);
  assign w_redir   = wpcir & (pcsource != PCSRC_SEQ);
  assign w_word    = (r_state == HOLD) ? r_ibuf : imem_rdata;
`ifdef PIPE_IF_SQUASH_EN
  assign w_squash  = w_redir | r_redir_pend;
`else
  assign w_squash  = 1'b0;
`endif

  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_dinst      = r_dinst;
    w_dpc4       = r_dpc4;
    w_dvalid     = r_dvalid;
    w_ibuf       = r_ibuf;
    w_redir_pc   = r_redir_pc;
    w_redir_pend = r_redir_pend;
    if (w_take) begin
      w_state      = FETCH;
      w_pc         = w_redir ? w_tgt : r_redir_pend ? r_redir_pc : w_pc4;
      w_dinst      = w_squash ? NOP_INST : w_word;
      w_dpc4       = w_pc4;
      w_dvalid     = ~w_squash;
      w_redir_pend = 1'b0;
    end else if (wpcir) begin
      w_dinst  = NOP_INST;
      w_dvalid = 1'b0;
      if (w_redir) begin
        w_redir_pc   = w_tgt;
        w_redir_pend = 1'b1;
      end
    end else if (w_done) begin
      w_ibuf  = imem_rdata;
      w_state = HOLD;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_dinst      <= NOP_INST;
      r_dpc4       <= '0;
      r_dvalid     <= 1'b0;
      r_ibuf       <= '0;
      r_redir_pc   <= '0;
      r_redir_pend <= 1'b0;
      r_started    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_dinst      <= w_dinst;
      r_dpc4       <= w_dpc4;
      r_dvalid     <= w_dvalid;
      r_ibuf       <= w_ibuf;
      r_redir_pc   <= w_redir_pc;
      r_redir_pend <= w_redir_pend;
      r_started    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: directed checks of fetch, stall, redirect, wrap and async reset.
module tb_pipe_if_stage;
  import pipe_pkg::*;
`ifdef PIPE_IF_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  logic        clock = 1'b0, resetn, wpcir, imem_ready, imem_req, dvalid;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc, imem_addr, imem_rdata, pc, dinst, dpc4;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  // memory word encodes its own address so every fetch is traceable
  function automatic logic [31:0] iw(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction
  assign imem_rdata = iw(imem_addr);

  pipe_if_stage #(.RESET_PC(32'h0)) dut (
    .clock(clock), .resetn(resetn), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .dinst(dinst),
    .dpc4(dpc4), .dvalid(dvalid)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                        input logic [31:0] e_pc4, input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".dinst"}, dinst, e_inst);
    chk({tag, ".dpc4"}, dpc4, e_pc4);
    chk({tag, ".dvalid"}, {31'b0, dvalid}, {31'b0, e_valid});
  endtask

  initial begin
    resetn = 1'b0; wpcir = 1'b1; pcsource = PCSRC_SEQ;
    bpc = '0; da = '0; jpc = '0; imem_ready = 1'b1;
    tick; tick;
    chk_if("rst", 32'h0, NOP_INST, 32'h0, 1'b0);
    chk("rst.req", {31'b0, imem_req}, 32'd0);
    resetn = 1'b1;
    tick;
    chk("first.req", {31'b0, imem_req}, 32'd1);
    chk_if("first", 32'h0, NOP_INST, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk_if("seq", 32'(4 * i), iw(32'(4 * (i - 1))), 32'(4 * i), 1'b1);
    end
    wpcir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk_if("stall", 32'h10, iw(32'hC), 32'h10, 1'b1);
      chk("stall.req", {31'b0, imem_req}, 32'd0);
    end
    wpcir = 1'b1; imem_ready = 1'b0;
    tick;
    chk_if("unstall", 32'h14, iw(32'h10), 32'h14, 1'b1);
    imem_ready = 1'b1;
    for (int a = 32'h18; a <= 32'h20; a += 4) begin
      tick;
      chk_if("seq2", 32'(a), iw(32'(a - 4)), 32'(a), 1'b1);
    end
    pcsource = PCSRC_BR; bpc = 32'h100;
    tick;
    chk_if("br", 32'h100, SQ ? NOP_INST : iw(32'h20), 32'h24, !SQ);
    pcsource = PCSRC_SEQ; bpc = '0;
    tick;
    chk_if("br_tgt", 32'h104, iw(32'h100), 32'h104, 1'b1);
    imem_ready = 1'b0; pcsource = PCSRC_J; jpc = 32'h400;
    tick;
    chk("wait1.pc", pc, 32'h104);
    chk("wait1.dinst", dinst, NOP_INST);
    chk("wait1.dvalid", {31'b0, dvalid}, 32'd0);
    pcsource = PCSRC_SEQ; jpc = '0;
    tick;
    chk("wait2.pc", pc, 32'h104);
    chk("wait2.dvalid", {31'b0, dvalid}, 32'd0);
    imem_ready = 1'b1;
    tick;
    chk_if("pend_done", 32'h400, SQ ? NOP_INST : iw(32'h104), 32'h108, !SQ);
    tick;
    chk_if("j_tgt", 32'h404, iw(32'h400), 32'h404, 1'b1);
    pcsource = PCSRC_JR; da = 32'h2000;
    tick;
    chk_if("jr", 32'h2000, SQ ? NOP_INST : iw(32'h404), 32'h408, !SQ);
    pcsource = PCSRC_J; jpc = 32'hFFFF_FFFC;
    tick;
    chk_if("j_wrap", 32'hFFFF_FFFC, SQ ? NOP_INST : iw(32'h2000), 32'h2004, !SQ);
    pcsource = PCSRC_SEQ;
    tick;
    chk_if("wrap", 32'h0, iw(32'hFFFF_FFFC), 32'h0, 1'b1);
    tick;
    chk_if("after_wrap", 32'h4, iw(32'h0), 32'h4, 1'b1);
    wpcir = 1'b0;
    tick;
    chk_if("hold", 32'h4, iw(32'h0), 32'h4, 1'b1);
    chk("hold.req", {31'b0, imem_req}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk_if("async_rst", 32'h0, NOP_INST, 32'h0, 1'b0);
    chk("async_rst.req", {31'b0, imem_req}, 32'd0);
    tick;
    chk_if("in_rst", 32'h0, NOP_INST, 32'h0, 1'b0);
    resetn = 1'b1; wpcir = 1'b1;
    tick;
    chk("rel.req", {31'b0, imem_req}, 32'd1);
    chk_if("rel", 32'h0, NOP_INST, 32'h0, 1'b0);
    tick;
    chk_if("post_rst", 32'h4, iw(32'h0), 32'h4, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
